// File: rtl/cpu_pkg.sv
// Shared state encoding, requester IDs and default SRAM read latency for the arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StAck   = 2'd3
    } arb_state_e;

    localparam logic REQ_DEC = 1'b0;
    localparam logic REQ_LCD = 1'b1;

    localparam int unsigned RD_LAT_DEFAULT = 1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle; slave is the arbiter side, master the requester/SRAM side.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              dec_req;
    logic              lcd_req;
    logic              dec_wr;
    logic              lcd_wr;
    logic [ADDR_W-1:0] dec_addr;
    logic [ADDR_W-1:0] lcd_addr;
    logic [DATA_W-1:0] dec_wdata;
    logic [DATA_W-1:0] lcd_wdata;
    logic              dec_ack;
    logic              lcd_ack;
    logic [DATA_W-1:0] dec_rdata;
    logic [DATA_W-1:0] lcd_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_rd_en;
    logic              sram_wr_en;
    logic [DATA_W-1:0] sram_wr_data;
    logic [DATA_W-1:0] sram_rd_data;

    modport slave (
        input  dec_req, lcd_req, dec_wr, lcd_wr, dec_addr, lcd_addr, dec_wdata, lcd_wdata,
        input  sram_rd_data,
        output dec_ack, lcd_ack, dec_rdata, lcd_rdata,
        output sram_addr, sram_rd_en, sram_wr_en, sram_wr_data
    );

    modport master (
        output dec_req, lcd_req, dec_wr, lcd_wr, dec_addr, lcd_addr, dec_wdata, lcd_wdata,
        output sram_rd_data,
        input  dec_ack, lcd_ack, dec_rdata, lcd_rdata,
        input  sram_addr, sram_rd_en, sram_wr_en, sram_wr_data
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the one not served last.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = ~last;
        if (req == 2'b01) begin
            winner = REQ_DEC;
        end else if (req == 2'b10) begin
            winner = REQ_LCD;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates decoder and LCD driver access to a single-port SRAM, one transaction at a time.
module sram_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          sys_rst,
    sram_arbiter_if.slave bus
);

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_d;
    logic              r_id;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_cnt;
    logic              r_last;
    logic [DATA_W-1:0] r_dec_rdata;
    logic [DATA_W-1:0] r_lcd_rdata;

    logic [1:0]        w_req;
    logic              w_winner;
    logic              w_latch;
    logic              w_capture;

    assign w_req = {bus.lcd_req, bus.dec_req};

    rr_arb2 u_rr_arb2 (
        .req    (w_req),
        .last   (r_last),
        .winner (w_winner)
    );

    assign bus.sram_addr    = r_addr;
    assign bus.sram_wr_data = r_wdata;
    assign bus.dec_rdata    = r_dec_rdata;
    assign bus.lcd_rdata    = r_lcd_rdata;

    always_comb begin
        w_state_d      = r_state;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        bus.sram_rd_en = 1'b0;
        bus.sram_wr_en = 1'b0;
        bus.dec_ack    = 1'b0;
        bus.lcd_ack    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|w_req) begin
                    w_latch   = 1'b1;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                bus.sram_wr_en = r_wr;
                bus.sram_rd_en = ~r_wr;
                w_state_d      = r_wr ? StAck : StWait;
            end
            StWait: begin
                // Read data is valid on the last WAIT cycle, when the counter reaches zero.
                if (r_cnt == 3'd0) begin
                    w_capture = 1'b1;
                    w_state_d = StAck;
                end
            end
            StAck: begin
                bus.dec_ack = (r_id == REQ_DEC);
                bus.lcd_ack = (r_id == REQ_LCD);
                w_state_d   = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state     <= StIdle;
            r_id        <= REQ_DEC;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= 3'd0;
            r_last      <= REQ_LCD;
            r_dec_rdata <= '0;
            r_lcd_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_latch) begin
                r_id    <= w_winner;
                r_wr    <= (w_winner == REQ_LCD) ? bus.lcd_wr    : bus.dec_wr;
                r_addr  <= (w_winner == REQ_LCD) ? bus.lcd_addr  : bus.dec_addr;
                r_wdata <= (w_winner == REQ_LCD) ? bus.lcd_wdata : bus.dec_wdata;
            end
            if (r_state == StIssue) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == StWait && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_capture) begin
                if (r_id == REQ_DEC) begin
                    r_dec_rdata <= bus.sram_rd_data;
                end else begin
                    r_lcd_rdata <= bus.sram_rd_data;
                end
            end
            if (r_state == StAck) begin
                r_last <= r_id;
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, cycles from sram_rd_en to valid sram_rd_data (legal range 1..7).
REQ-004 The block SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1, reset that is synchronous and active-high.
REQ-006 The block SHALL have ports dec_req, lcd_req, input, 1 each, level request from the decoder and the LCD driver.
REQ-007 The block SHALL have ports dec_wr, lcd_wr, input, 1 each, 1 = write and 0 = read.
REQ-008 The block SHALL have ports dec_addr, lcd_addr, input, ADDR_W each, access address.
REQ-009 The block SHALL have ports dec_wdata, lcd_wdata, input, DATA_W each, write data.
REQ-010 The block SHALL have ports dec_ack, lcd_ack, output, 1 each, single-cycle completion pulse.
REQ-011 The block SHALL have ports dec_rdata, lcd_rdata, output, DATA_W each, read data, valid while the matching ack is high.
REQ-012 The block SHALL have port sram_addr, output, ADDR_W, SRAM address.
REQ-013 The block SHALL have ports sram_rd_en and sram_wr_en, output, 1 each, SRAM strobes.
REQ-014 The block SHALL have port sram_wr_data, output, DATA_W, SRAM write data.
REQ-015 The block SHALL have port sram_rd_data, input, DATA_W, SRAM read data.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and ACK.
REQ-017 In IDLE with any req high, the block SHALL arbitrate, latch the winner ID, wr, addr and wdata, and go to ISSUE; with no req high it SHALL remain in IDLE.
REQ-018 Arbitration SHALL be two-way round-robin: a sole requester wins, and on a simultaneous request the requester not served last wins.
REQ-019 The ISSUE state SHALL last exactly one cycle: sram_addr equals the latched addr, and either sram_wr_en=1 with sram_wr_data equal to the latched wdata, or sram_rd_en=1.
REQ-020 After ISSUE, a write SHALL go directly to ACK.
REQ-021 After ISSUE, a read SHALL go to WAIT for RD_LAT cycles using a 3-bit down-counter, capture sram_rd_data on the last WAIT cycle, then go to ACK.
REQ-022 In ACK (one cycle), the block SHALL assert only the winner's ack with the captured rdata, update the last-served pointer, and return to IDLE.
REQ-023 Latency from req sampled in IDLE to ack SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-024 Requesters SHALL hold req, wr, addr and wdata until ack and deassert req on the edge that samples ack; the block SHALL ignore input changes after the latch in IDLE.
REQ-025 A req dropped mid-transaction SHALL NOT abort the transaction; the access completes and ack still pulses.
REQ-026 Back-to-back transactions SHALL be separated by at least one IDLE cycle, so no requester waits longer than one foreign transaction.
REQ-027 Outside ISSUE, sram_rd_en and sram_wr_en SHALL be 0; at most one strobe SHALL be high in any cycle.
REQ-028 rdata outputs SHALL hold their last captured value when ack is low; a write ack SHALL leave rdata unchanged.

Reset
REQ-029 On sys_rst high at a clk edge, the block SHALL enter IDLE, clear all ack outputs and strobes to 0, clear sram_addr, sram_wr_data, the rdata outputs and the counter to 0, and set the last-served pointer to LCD (decoder wins the first tie).
REQ-030 A reset during ISSUE or WAIT SHALL abandon the access with no ack, and the strobes SHALL be 0 in the cycle after the edge.

Structure
REQ-031 The state encoding, the requester IDs (REQ_DEC=0, REQ_LCD=1) and the RD_LAT default SHALL reside in the shared package cpu_pkg.
REQ-032 The round-robin picker SHALL be a sub-module rr_arb2, combinational, with inputs req[1:0] and last, and output winner.

Verification
REQ-033 The bench SHALL cover: dec write addr 0x10 data 0xA5 -> sram_wr_en one cycle with addr 0x10 and data 0xA5, then dec_ack 2 cycles after request.
REQ-034 The bench SHALL cover: lcd read addr 0x10 with RD_LAT=1 -> sram_rd_en one cycle, then lcd_ack 3 cycles after request with lcd_rdata=0xA5.
REQ-035 The bench SHALL cover: dec_req and lcd_req raised in the same cycle after reset -> dec served first, lcd served next with one IDLE cycle between, with no overlapping strobes.
REQ-036 The bench SHALL cover: both requesters holding req continuously for 6 transactions -> grants alternate dec, lcd, dec, and so on.
REQ-037 The bench SHALL cover: sys_rst asserted in a WAIT cycle -> no ack, strobes 0 the next cycle, then a fresh dec read completes normally.
REQ-038 The bench SHALL cover: dec_req dropped during WAIT with RD_LAT=3 -> dec_ack still pulses 5 cycles after request.
